// File: rtl/merge_output_packer.sv
// Output stage behind the 4-wide merger: skid FIFO, beat-pair packer into 8-record words,
// run terminator detection with run-length reporting.
module merge_output_packer #(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 80,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [4*DATA_WIDTH-1:0]   i_data,
  input  logic                      i_write,
  output logic                      o_ready,
  output logic [8*DATA_WIDTH-1:0]   o_data,
  output logic                      o_valid,
  input  logic                      i_out_ready,
  output logic                      o_last,
  output logic [CNT_WIDTH-1:0]      o_run_beats,
  output logic                      o_run_done,
  output logic                      o_overflow
);

  localparam int AW     = $clog2(DEPTH);
  localparam int BEAT_W = 4 * DATA_WIDTH;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_HALF  = 1'b1;

  logic [BEAT_W-1:0]    mem [DEPTH];
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [AW:0]          count;
  logic                 state;
  logic [BEAT_W-1:0]    low_beat;
  logic [CNT_WIDTH-1:0] beat_cnt;

  logic [BEAT_W-1:0]    head;
  logic                 head_term;
  logic                 out_free;
  logic                 pop;
  logic                 full_after_pop;
  logic                 push;

  assign head = mem[rd_ptr];
  // Record 0 all-zero: key field and payload both checked.
  assign head_term = (head[KEY_WIDTH-1:0] == '0) &&
                     (head[DATA_WIDTH-1:KEY_WIDTH] == '0);

  assign out_free = ~o_valid | i_out_ready;

  // A non-terminator head may move into the low half even while the output is stalled.
  always_comb begin
    pop = 1'b0;
    if (count != '0) begin
      if (state == ST_HALF || head_term) pop = out_free;
      else                               pop = 1'b1;
    end
  end

  assign full_after_pop = ((count - {{AW{1'b0}}, pop}) == (AW+1)'(DEPTH));
  assign push           = i_write & ~full_after_pop;

  // Two entries of slack cover the write that lands after the merger's registered ready drops.
  assign o_ready = (((AW+1)'(DEPTH) - count) >= (AW+1)'(2));

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_EMPTY;
      low_beat   <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (i_write && full_after_pop) o_overflow <= 1'b1;
      if (o_valid && i_out_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
      if (pop) begin
        if (state == ST_EMPTY) begin
          if (head_term) begin
            o_data  <= {{BEAT_W{1'b0}}, head};
            o_valid <= 1'b1;
            o_last  <= 1'b1;
          end else begin
            low_beat <= head;
            state    <= ST_HALF;
          end
        end else begin
          o_data  <= {head, low_beat};
          o_valid <= 1'b1;
          o_last  <= head_term;
          state   <= ST_EMPTY;
        end
      end
    end
  end

  // Run length includes the terminator; the done pulse coincides with the o_last word appearing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_cnt    <= '0;
      o_run_beats <= '0;
      o_run_done  <= 1'b0;
    end else begin
      o_run_done <= 1'b0;
      if (pop) begin
        if (head_term) begin
          o_run_beats <= beat_cnt + 1'b1;
          beat_cnt    <= '0;
          o_run_done  <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_merge_output_packer.sv
// Directed and randomized bench for merge_output_packer against a queue-based reference model.
module tb_merge_output_packer;

  localparam int DATA_WIDTH = 128;
  localparam int KEY_WIDTH  = 80;
  localparam int DEPTH      = 8;
  localparam int CNT_WIDTH  = 32;
  localparam int BEAT_W     = 4 * DATA_WIDTH;
  localparam int WORD_W     = 8 * DATA_WIDTH;

  logic                  i_clk;
  logic                  i_rst_n;
  logic [BEAT_W-1:0]     i_data;
  logic                  i_write;
  logic                  o_ready;
  logic [WORD_W-1:0]     o_data;
  logic                  o_valid;
  logic                  i_out_ready;
  logic                  o_last;
  logic [CNT_WIDTH-1:0]  o_run_beats;
  logic                  o_run_done;
  logic                  o_overflow;

  int checks = 0;
  int errors = 0;

  merge_output_packer #(
    .DATA_WIDTH(DATA_WIDTH), .KEY_WIDTH(KEY_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_write(i_write),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_out_ready(i_out_ready),
    .o_last(o_last), .o_run_beats(o_run_beats), .o_run_done(o_run_done),
    .o_overflow(o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: accepted beats in a queue, pairs form words, terminators close runs.
  logic [BEAT_W-1:0]    m_q[$];
  bit                   m_half;
  logic [BEAT_W-1:0]    m_low;
  logic                 m_valid, m_last, m_done, m_ovf;
  logic [WORD_W-1:0]    m_data;
  logic [CNT_WIDTH-1:0] m_cnt, m_run;

  always @(posedge i_clk or negedge i_rst_n) begin : model_step
    bit free, pop, term, full_after;
    logic [BEAT_W-1:0] head;
    if (!i_rst_n) begin
      m_q.delete();
      m_half = 0; m_low = '0; m_valid = 0; m_last = 0; m_done = 0; m_ovf = 0;
      m_data = '0; m_cnt = '0; m_run = '0;
    end else begin
      free = !m_valid || i_out_ready;
      pop = 0; term = 0; head = '0;
      if (m_q.size() != 0) begin
        head = m_q[0];
        term = (head[DATA_WIDTH-1:0] == '0);
        pop  = (m_half || term) ? free : 1'b1;
      end
      full_after = (m_q.size() - (pop ? 1 : 0)) >= DEPTH;
      if (m_valid && i_out_ready) begin m_valid = 0; m_last = 0; end
      m_done = 0;
      if (pop) begin
        void'(m_q.pop_front());
        if (term) begin m_run = m_cnt + 1; m_cnt = '0; m_done = 1; end
        else m_cnt = m_cnt + 1;
        if (!m_half) begin
          if (term) begin m_data = {{BEAT_W{1'b0}}, head}; m_valid = 1; m_last = 1; end
          else begin m_low = head; m_half = 1; end
        end else begin
          m_data = {head, m_low}; m_valid = 1; m_last = term; m_half = 0;
        end
      end
      if (i_write) begin
        if (full_after) m_ovf = 1;
        else m_q.push_back(i_data);
      end
    end
  end

  function automatic logic [BEAT_W-1:0] rand_beat(bit term);
    logic [BEAT_W-1:0] b;
    for (int w = 0; w < BEAT_W/32; w++) b[w*32 +: 32] = $urandom;
    if (term) b[DATA_WIDTH-1:0] = '0;
    else if (b[DATA_WIDTH-1:0] == '0) b[0] = 1'b1;
    return b;
  endfunction

  task automatic checkVal(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkData(string tag, logic [WORD_W-1:0] obs, logic [WORD_W-1:0] exp);
    int idx;
    idx = 0;
    for (int r = 7; r >= 0; r--) if (obs[r*DATA_WIDTH +: DATA_WIDTH] !== exp[r*DATA_WIDTH +: DATA_WIDTH]) idx = r;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s record %0d observed=%h expected=%h", tag, idx,
             obs[idx*DATA_WIDTH +: DATA_WIDTH], exp[idx*DATA_WIDTH +: DATA_WIDTH]);
    end
  endtask

  task automatic checkOutput();
    checkVal("valid", 64'(o_valid), 64'(m_valid));
    if (m_valid) begin
      checkVal("last", 64'(o_last), 64'(m_last));
      checkData("data", o_data, m_data);
    end
    checkVal("ready", 64'(o_ready), 64'((DEPTH - m_q.size()) >= 2));
    checkVal("overflow", 64'(o_overflow), 64'(m_ovf));
    checkVal("run_done", 64'(o_run_done), 64'(m_done));
    checkVal("run_beats", 64'(o_run_beats), 64'(m_run));
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
    checkOutput();
  endtask

  task automatic applyStimulus(bit wr, logic [BEAT_W-1:0] d);
    i_write = wr;
    i_data  = d;
    step();
  endtask

  task automatic applyReset();
    @(negedge i_clk);
    i_rst_n = 1'b0; i_write = 1'b0; i_out_ready = 1'b1; i_data = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic waitLast(string tag);
    bit seen;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (o_valid && o_last) seen = 1;
      else applyStimulus(1'b0, '0);
    end
    checkVal(tag, 64'(seen), 64'd1);
  endtask

  task automatic drain(string tag);
    bit done;
    done = 0;
    i_write = 1'b0;
    i_out_ready = 1'b1;
    for (int n = 0; n < 60 && !done; n++) begin
      if (m_q.size() == 0 && !m_valid && !o_valid) done = 1;
      else step();
    end
    checkVal(tag, 64'(done), 64'd1);
  endtask

  initial begin : stimulus
    logic [BEAT_W-1:0] a, b, c, t, b0, b1, b2, b3;
    bit ready_q;
    a = {128'd4, 128'd3, 128'd2, 128'd1};
    b = {128'd8, 128'd7, 128'd6, 128'd5};
    c = {128'd12, 128'd11, 128'd10, 128'd9};
    t = '0;
    i_rst_n = 1'b1; i_write = 1'b0; i_out_ready = 1'b1; i_data = '0;

    // Reset values
    applyReset();
    checkVal("rst_valid", 64'(o_valid), 64'd0);
    checkVal("rst_ready", 64'(o_ready), 64'd1);
    checkVal("rst_ovf", 64'(o_overflow), 64'd0);
    checkVal("rst_run_beats", 64'(o_run_beats), 64'd0);
    checkData("rst_data", o_data, '0);

    // Two-beat pack latency
    applyStimulus(1'b1, a);
    applyStimulus(1'b1, b);
    checkVal("lat_early_valid", 64'(o_valid), 64'd0);
    applyStimulus(1'b0, '0);
    checkVal("lat_valid", 64'(o_valid), 64'd1);
    checkData("lat_data", o_data, {b, a});
    checkVal("lat_last", 64'(o_last), 64'd0);
    drain("lat_drain");

    // Run of four with terminator in the high half
    applyReset();
    applyStimulus(1'b1, a);
    applyStimulus(1'b1, b);
    applyStimulus(1'b1, c);
    applyStimulus(1'b1, t);
    i_write = 1'b0;
    waitLast("run4_last_seen");
    checkData("run4_data", o_data, {t, c});
    checkVal("run4_beats", 64'(o_run_beats), 64'd4);
    checkVal("run4_done", 64'(o_run_done), 64'd1);
    applyStimulus(1'b0, '0);
    checkVal("run4_done_pulse", 64'(o_run_done), 64'd0);
    drain("run4_drain");

    // Lone terminator from EMPTY
    applyStimulus(1'b1, t);
    i_write = 1'b0;
    waitLast("term1_last_seen");
    checkData("term1_data", o_data, '0);
    checkVal("term1_beats", 64'(o_run_beats), 64'd1);
    drain("term1_drain");

    // Fill with output stalled, then overflow
    applyReset();
    i_out_ready = 1'b0;
    for (int n = 0; n < 4*DEPTH && o_ready; n++) applyStimulus(1'b1, rand_beat(0));
    checkVal("fill_ready_low", 64'(o_ready), 64'd0);
    applyStimulus(1'b1, rand_beat(0));
    checkVal("slack_no_ovf", 64'(o_overflow), 64'd0);
    applyStimulus(1'b1, rand_beat(0));
    checkVal("ovf_set", 64'(o_overflow), 64'd1);
    drain("ovf_drain");
    checkVal("ovf_sticky", 64'(o_overflow), 64'd1);

    // Output stall keeps the word stable
    applyReset();
    b0 = rand_beat(0); b1 = rand_beat(0); b2 = rand_beat(0); b3 = rand_beat(0);
    i_out_ready = 1'b0;
    applyStimulus(1'b1, b0);
    applyStimulus(1'b1, b1);
    applyStimulus(1'b1, b2);
    applyStimulus(1'b1, b3);
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b0, '0);
      checkVal("stall_valid", 64'(o_valid), 64'd1);
      checkData("stall_data", o_data, {b1, b0});
    end
    i_out_ready = 1'b1;
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);
    checkData("stall_resume", o_data, {b3, b2});
    drain("stall_drain");

    // Asynchronous reset while a word is held and a low half is pending
    applyReset();
    i_out_ready = 1'b0;
    applyStimulus(1'b1, b0);
    applyStimulus(1'b1, b1);
    applyStimulus(1'b1, b2);
    applyStimulus(1'b0, '0);
    checkVal("pre_rst_valid", 64'(o_valid), 64'd1);
    #2 i_rst_n = 1'b0;
    #1;
    checkVal("async_rst_valid", 64'(o_valid), 64'd0);
    checkVal("async_rst_ready", 64'(o_ready), 64'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_out_ready = 1'b1;
    applyStimulus(1'b1, c);
    applyStimulus(1'b1, a);
    applyStimulus(1'b0, '0);
    checkData("post_rst_word", o_data, {a, c});
    checkVal("post_rst_last", 64'(o_last), 64'd0);
    drain("post_rst_drain");

    // Randomized traffic; writes follow a one-cycle-late view of o_ready like the merger
    applyReset();
    ready_q = 1'b1;
    for (int n = 0; n < 400; n++) begin
      i_out_ready = ($urandom_range(3) != 0);
      applyStimulus(ready_q && ($urandom_range(3) != 0), rand_beat($urandom_range(5) == 0));
      ready_q = o_ready;
    end
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/merge_output_packer.md
Name: merge_output_packer

Overview:
- Sits directly downstream of the 4-wide merger.
- Accepts merged 4-record beats on a write strobe and buffers them in a skid FIFO sized for the merger's registered ready.
- Packs pairs of beats into 8-record words for the memory writer.
- Detects the all-zero terminator that ends a sorted run, flushes the partial pack and reports the run length.

Parameters:
DATA_WIDTH, 128, width of one record
KEY_WIDTH, 80, key field width (record bits KEY_WIDTH-1:0); carried for interface consistency, no comparison done here
DEPTH, 8, input FIFO entries (power of 2, >=4)
CNT_WIDTH, 32, width of run beat counter

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_data  in  4*DATA_WIDTH  merged beat, record 0 in bits DATA_WIDTH-1:0
i_write  in  1  beat valid this cycle (merger o_out_fifo_write)
o_ready  out  1  space available; drives merger i_fifo_out_ready
o_data  out  8*DATA_WIDTH  packed word; earlier beat in low half
o_valid  out  1  o_data valid
i_out_ready  in  1  downstream accepts o_data when o_valid & i_out_ready
o_last  out  1  packed word contains the run terminator (qualified by o_valid)
o_run_beats  out  CNT_WIDTH  beats in last completed run, terminator included
o_run_done  out  1  one-cycle pulse when o_run_beats updates
o_overflow  out  1  sticky: a write arrived while FIFO full

Behaviour:
- Reset: one clock, i_clk. Asynchronous active-low reset on i_rst_n. Asserting i_rst_n low forces the following at any time, mid-pack included; the partial pack is discarded:
  - o_valid=0, o_last=0, o_run_done=0, o_overflow=0
  - o_run_beats=0, o_data=0
  - FIFO empty, packer state EMPTY, internal beat counter 0
  - o_ready=1 after reset
- o_ready is combinational from the registered occupancy: o_ready = (DEPTH - count) >= 2. Two entries of slack are required because the merger registers ready, so one more write can land after deassert.
- Write with FIFO full: beat dropped, o_overflow set, held until reset. A simultaneous pop frees space, so "full" is evaluated after that cycle's pop.
- Terminator: a beat whose record 0 (bits DATA_WIDTH-1:0) == 0.
- Packer FSM:
  - EMPTY: if FIFO head is available and the output register is free or being accepted this cycle, pop the head.
    - Head is a terminator: load o_data = {zeros, head}, o_last=1, o_valid=1; stay EMPTY.
    - Otherwise: latch head as the low half and go to HALF.
  - HALF: under the same pop condition, pop the head and load o_data = {head, low}, o_valid=1, o_last = (head is terminator); go to EMPTY.
  - Output register free means o_valid=0, or o_valid & i_out_ready this cycle (full throughput, one word per 2 pops).
  - Output held stable while o_valid & ~i_out_ready; no pops that complete a word occur then. A pop into HALF is allowed while the output is stalled.
- Latency: FIFO is registered, one cycle write to head. With the FIFO empty and the output idle, o_valid rises 2 cycles after the write cycle of the completing beat.
- Run counter:
  - Increments per popped beat.
  - When the terminator is popped: o_run_beats <= counter+1 and counter <= 0 on the same edge.
  - o_run_done pulses in the cycle o_valid&o_last first appears.
  - Counter wraps modulo 2^CNT_WIDTH silently.
- Simultaneous write and pop on a full FIFO is accepted (count unchanged). Write and pop on an empty FIFO does not bypass; the beat is seen next cycle.
- Consecutive terminators each produce their own o_last word.

Test Plan:
- Reset, then write beats A=1..4 (records 1,2,3,4) and B=5..8 back to back, i_out_ready=1 -> o_valid 2 cycles after B's write, o_data={B,A}, o_last=0.
- Write A(records 1..4), B, C, then terminator T=0 -> words {B,A} then {zeros... ,T} is not produced; instead {T,C} with o_last=1, o_run_beats=4, o_run_done pulse one cycle.
- Write single terminator from EMPTY -> o_data={0,0}, o_last=1, o_run_beats=1.
- Hold i_out_ready=0, write continuous beats -> o_ready drops when count reaches DEPTH-1, one extra write after drop still accepted, o_overflow stays 0. Force a write at count=DEPTH -> o_overflow=1, sticky.
- Stall output with o_valid high for 5 cycles -> o_data/o_last stable; release -> stream resumes in order, no loss or duplication.
- Assert i_rst_n low while in HALF with o_valid=1 -> o_valid=0 immediately (async), after release o_ready=1, next two beats form a fresh word.
